bomb_game_ctrl: RTL and testbench
=================================

BOMB_GAME_CTRL -- requirements
Module: bomb_game_ctrl

Interface
REQ-001 Parameter CODE_W, default 5: width of the generated code.
REQ-002 Parameter TICK_DIV, default 50000000: clk cycles per one-second tick.
REQ-003 Parameter SHOW_S, default 3: seconds the code is displayed.
REQ-004 Parameter TIME_S, default 20: defuse countdown in seconds; range 1..255.
REQ-005 Parameter RESULT_S, default 3: seconds a result is held before auto-restart.
REQ-006 clk  in  1  system clock; all logic on posedge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 sw_en  in  1  master switch; asynchronous to clk.
REQ-009 btn_start  in  1  start button; asynchronous, level.
REQ-010 input_done  in  1  one-cycle pulse from the code-entry block.
REQ-011 input_ok  in  1  entry matched; sampled only with input_done.
REQ-012 bomb_on  out  1  bomb display enable.
REQ-013 code  out  CODE_W  current secret code.
REQ-014 show_on  out  1  code display enable.
REQ-015 timer_on  out  1  countdown display enable.
REQ-016 input_on  out  1  code-entry enable.
REQ-017 sec_left  out  8  remaining seconds.
REQ-018 success  out  1  smiley display enable.
REQ-019 fail  out  1  crying-face display enable.

Function
REQ-020 Synchronise sw_en and btn_start with 2-flop synchronisers; a start event is a one-cycle rising edge of the synchronised btn_start.
REQ-021 Run a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) that advances every cycle while synchronised sw_en=1.
REQ-022 FSM states: OFF, IDLE, SHOW, ARMED, WIN, LOSE. All outputs are registered and change one cycle after the transition.
REQ-023 Synchronised sw_en=0 forces OFF from any state, with highest priority. In OFF all outputs are 0 except code, which holds.
REQ-024 OFF->IDLE when synchronised sw_en=1. In IDLE: bomb_on=1; all other enables are 0.
REQ-025 IDLE, WIN or LOSE + start event -> SHOW. On this transition, latch code from lfsr[CODE_W-1:0]; if that value is 0, latch 1.
REQ-026 SHOW: bomb_on=1, show_on=1, sec_left=SHOW_S, decrementing per tick. At the tick where sec_left reaches 0 -> ARMED.
REQ-027 ARMED: bomb_on, timer_on and input_on=1. sec_left loads TIME_S on entry and decrements per tick.
REQ-028 In ARMED: input_done with input_ok=1 -> WIN; input_done with input_ok=0 -> LOSE; the tick where sec_left reaches 0 -> LOSE.
REQ-029 If input_done and the expiring tick fall in the same cycle, input_done decides.
REQ-030 WIN: success=1, bomb_on=0. LOSE: fail=1, bomb_on=1. sec_left freezes at its final value in both.
REQ-031 Start events in SHOW and ARMED are ignored. input_done outside ARMED is ignored.
REQ-032 The tick divider clears on every state entry, so the first second of each state is a full TICK_DIV cycles.

Reset
REQ-033 rst_n=0 asynchronously sets: state=OFF, all outputs 0, code=0, LFSR=16'hACE1, divider=0, synchronisers=0.
REQ-034 Reset mid-game discards the game; after release the FSM re-enters via OFF->IDLE.

Configuration
REQ-035 With BOMB_AUTO_RESTART_EN defined: WIN/LOSE return to IDLE after RESULT_S ticks unless a start event comes first.
REQ-036 Without BOMB_AUTO_RESTART_EN: WIN/LOSE hold until a start event or sw_en=0; RESULT_S is unused.

Structure
REQ-037 Package bomb_game_pkg holds: the state enum, the LFSR width/taps/seed constants, and the sec_left width constant.
REQ-038 The divider is sub-module sec_tick_gen (TICK_DIV, clr input, one-cycle tick output). The FSM, LFSR and counters stay in bomb_game_ctrl.

Verification
REQ-039 Bench parameters: TICK_DIV=4, SHOW_S=2, TIME_S=3, RESULT_S=2.
REQ-040 Scenario, power-up: rst_n low then released, sw_en=1 -> IDLE within 4 cycles; bomb_on=1; all other enables 0; code=0.
REQ-041 Scenario, win: start pulse -> show_on=1 for 8 cycles; then ARMED with sec_left=3; input_done+input_ok=1 -> success=1 next cycle, bomb_on=0.
REQ-042 Scenario, timeout: no input in ARMED -> after 12 cycles fail=1 and sec_left=0.
REQ-043 Scenario, simultaneous events: input_done+input_ok=1 in the same cycle as the final tick -> WIN, not LOSE.
REQ-044 Scenario, switch off: sw_en=0 mid-ARMED -> all enables 0 within 3 cycles; sw_en=1 -> IDLE. Check also that two consecutive games latch different nonzero codes.
REQ-045 Scenario, result hold: with BOMB_AUTO_RESTART_EN, LOSE returns to IDLE after 8 cycles. Without it, LOSE persists for 100 cycles.

Source files
------------

// File: rtl/bomb_game_pkg.sv
// Shared state encoding, LFSR constants and display-enable bundle for bomb_game_ctrl.
// Combinational helper only; it adds no latency and has no flow control.
package bomb_game_pkg;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_IDLE,
      ST_SHOW,
      ST_ARMED,
      ST_WIN,
      ST_LOSE
   } state_t;

   localparam int LFSR_W = 16;
   // x^16+x^14+x^13+x^11+1 in right-shifting Galois form
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

   localparam int SEC_W = 8;

   typedef struct packed {
      logic bomb;
      logic show;
      logic timer;
      logic entry;
      logic win;
      logic lose;
   } disp_t;

   function automatic disp_t disp_of(input state_t s);
      disp_t d;
      d = '0;
      case (s)
         ST_IDLE:  d.bomb = 1'b1;
         ST_SHOW:  begin d.bomb = 1'b1; d.show = 1'b1; end
         ST_ARMED: begin d.bomb = 1'b1; d.timer = 1'b1; d.entry = 1'b1; end
         ST_WIN:   d.win = 1'b1;
         ST_LOSE:  begin d.bomb = 1'b1; d.lose = 1'b1; end
         default:  d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick divider: tick pulses on the TICK_DIV-th cycle after clr, clr cycle counted as the first.
// Tick is combinational from the count; no backpressure.
module sec_tick_gen #(
   parameter int TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt;
   logic [CW-1:0] base;

   // clr marks the first cycle of a new state, which already counts toward the second
   assign base = clr ? '0 : cnt;
   assign tick = (base == CW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= tick ? '0 : base + CW'(1);
      end
   end

endmodule

// File: rtl/bomb_game_ctrl.sv
// Bomb defuse game sequencer (OFF/IDLE/SHOW/ARMED/WIN/LOSE), outputs registered one cycle after a transition, no backpressure.
// Define BOMB_AUTO_RESTART_EN to return WIN/LOSE to IDLE after RESULT_S seconds.
module bomb_game_ctrl
   import bomb_game_pkg::*;
#(
   parameter int CODE_W   = 5,
   parameter int TICK_DIV = 50000000,
   parameter int SHOW_S   = 3,
   parameter int TIME_S   = 20,
   parameter int RESULT_S = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sw_en,
   input  logic              btn_start,
   input  logic              input_done,
   input  logic              input_ok,
   output logic              bomb_on,
   output logic [CODE_W-1:0] code,
   output logic              show_on,
   output logic              timer_on,
   output logic              input_on,
   output logic [SEC_W-1:0]  sec_left,
   output logic              success,
   output logic              fail
);

   logic [1:0]        sw_ff;
   logic [1:0]        btn_ff;
   logic              btn_d;
   logic              sw_s;
   logic              start;
   logic [LFSR_W-1:0] lfsr;
   logic [CODE_W-1:0] new_code;
   state_t            state;
   disp_t             disp;
   logic              entered;
   logic              tick;
`ifdef BOMB_AUTO_RESTART_EN
   logic [SEC_W-1:0]  res_left;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_ff  <= '0;
         btn_ff <= '0;
         btn_d  <= 1'b0;
      end else begin
         sw_ff  <= {sw_ff[0], sw_en};
         btn_ff <= {btn_ff[0], btn_start};
         btn_d  <= btn_ff[1];
      end
   end

   assign sw_s  = sw_ff[1];
   assign start = btn_ff[1] & ~btn_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= LFSR_SEED;
      end else if (sw_s) begin
         lfsr <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
      end
   end

   // an all-zero code cannot be entered on the keypad, so substitute 1
   assign new_code = (lfsr[CODE_W-1:0] == '0) ? CODE_W'(1) : lfsr[CODE_W-1:0];

   sec_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (entered),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_OFF;
         disp     <= '0;
         code     <= '0;
         sec_left <= '0;
         entered  <= 1'b0;
`ifdef BOMB_AUTO_RESTART_EN
         res_left <= '0;
`endif
      end else begin
         entered <= 1'b0;
         if (!sw_s) begin
            state    <= ST_OFF;
            disp     <= '0;
            sec_left <= '0;
            entered  <= 1'b1;
         end else begin
            case (state)
               ST_OFF: begin
                  state    <= ST_IDLE;
                  disp     <= disp_of(ST_IDLE);
                  sec_left <= '0;
                  entered  <= 1'b1;
               end
               ST_IDLE, ST_WIN, ST_LOSE: begin
                  if (start) begin
                     state    <= ST_SHOW;
                     disp     <= disp_of(ST_SHOW);
                     code     <= new_code;
                     sec_left <= SEC_W'(SHOW_S);
                     entered  <= 1'b1;
                  end
`ifdef BOMB_AUTO_RESTART_EN
                  else if (state != ST_IDLE && tick) begin
                     if (res_left == SEC_W'(1)) begin
                        state    <= ST_IDLE;
                        disp     <= disp_of(ST_IDLE);
                        sec_left <= '0;
                        entered  <= 1'b1;
                     end
                     res_left <= res_left - SEC_W'(1);
                  end
`endif
               end
               ST_SHOW: begin
                  if (tick) begin
                     if (sec_left == SEC_W'(1)) begin
                        state    <= ST_ARMED;
                        disp     <= disp_of(ST_ARMED);
                        sec_left <= SEC_W'(TIME_S);
                        entered  <= 1'b1;
                     end else begin
                        sec_left <= sec_left - SEC_W'(1);
                     end
                  end
               end
               ST_ARMED: begin
`ifdef BOMB_AUTO_RESTART_EN
                  res_left <= SEC_W'(RESULT_S);
`endif
                  // a verdict from the keypad outranks an expiring second
                  if (input_done) begin
                     state   <= input_ok ? ST_WIN : ST_LOSE;
                     disp    <= disp_of(input_ok ? ST_WIN : ST_LOSE);
                     entered <= 1'b1;
                  end else if (tick) begin
                     if (sec_left == SEC_W'(1)) begin
                        state   <= ST_LOSE;
                        disp    <= disp_of(ST_LOSE);
                        entered <= 1'b1;
                     end
                     sec_left <= sec_left - SEC_W'(1);
                  end
               end
               default: begin
                  state <= ST_OFF;
                  disp  <= '0;
               end
            endcase
         end
      end
   end

   assign bomb_on  = disp.bomb;
   assign show_on  = disp.show;
   assign timer_on = disp.timer;
   assign input_on = disp.entry;
   assign success  = disp.win;
   assign fail     = disp.lose;

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// Self-checking bench for bomb_game_ctrl: a phase/elapsed-time model checked every cycle plus directed scenarios.
module tb_bomb_game_ctrl;

   localparam int CODE_W   = 5;
   localparam int TICK_DIV = 4;
   localparam int SHOW_S   = 2;
   localparam int TIME_S   = 3;
   localparam int RESULT_S = 2;

   logic              clk;
   logic              rst_n;
   logic              sw_en;
   logic              btn_start;
   logic              input_done;
   logic              input_ok;
   logic              bomb_on;
   logic [CODE_W-1:0] code;
   logic              show_on;
   logic              timer_on;
   logic              input_on;
   logic [7:0]        sec_left;
   logic              success;
   logic              fail;

   int tests = 0;
   int fails = 0;
   logic chk_on = 1'b0;

   bomb_game_ctrl #(
      .CODE_W   (CODE_W),
      .TICK_DIV (TICK_DIV),
      .SHOW_S   (SHOW_S),
      .TIME_S   (TIME_S),
      .RESULT_S (RESULT_S)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_en      (sw_en),
      .btn_start  (btn_start),
      .input_done (input_done),
      .input_ok   (input_ok),
      .bomb_on    (bomb_on),
      .code       (code),
      .show_on    (show_on),
      .timer_on   (timer_on),
      .input_on   (input_on),
      .sec_left   (sec_left),
      .success    (success),
      .fail       (fail)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   // model: which phase the game is in and how many cycles it has been there
   typedef enum int {M_OFF, M_IDLE, M_SHOW, M_ARMED, M_WIN, M_LOSE} mphase_t;
   mphase_t     ph = M_OFF;
   mphase_t     nx = M_OFF;
   int          t = 0;
   int          fin = 0;
   logic [4:0]  m_code = '0;
   logic [15:0] m_lfsr = 16'hACE1;
   logic [15:0] lf_old;
   logic [1:0]  sw_q = '0;
   logic [1:0]  btn_q = '0;
   logic        btn_p = 1'b0;
   logic        sw_m;
   logic        start_m;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph = M_OFF; t = 0; fin = 0; m_code = '0; m_lfsr = 16'hACE1;
         sw_q = '0; btn_q = '0; btn_p = 1'b0;
      end else begin
         sw_m    = sw_q[1];
         start_m = btn_q[1] & ~btn_p;
         lf_old  = m_lfsr;
         sw_q    = {sw_q[0], sw_en};
         btn_p   = btn_q[1];
         btn_q   = {btn_q[0], btn_start};
         if (sw_m) m_lfsr = lfsr_step(m_lfsr);
         nx = ph;
         if (!sw_m) nx = M_OFF;
         else begin
            case (ph)
               M_OFF:  nx = M_IDLE;
               M_IDLE: if (start_m) nx = M_SHOW;
               M_SHOW: if (t == SHOW_S * TICK_DIV - 1) nx = M_ARMED;
               M_ARMED: begin
                  if (input_done) begin
                     nx  = input_ok ? M_WIN : M_LOSE;
                     fin = TIME_S - t / TICK_DIV;
                  end else if (t == TIME_S * TICK_DIV - 1) begin
                     nx  = M_LOSE;
                     fin = 0;
                  end
               end
               default: begin
                  if (start_m) nx = M_SHOW;
`ifdef BOMB_AUTO_RESTART_EN
                  else if (t == RESULT_S * TICK_DIV - 1) nx = M_IDLE;
`endif
               end
            endcase
         end
         if (nx == M_SHOW && ph != M_SHOW) m_code = (lf_old[4:0] == 5'd0) ? 5'd1 : lf_old[4:0];
         t  = (nx != ph) ? 0 : t + 1;
         ph = nx;
      end
   end

   logic [5:0] exp_disp;
   int         exp_sec;

   always @(negedge clk) begin
      if (rst_n && chk_on) begin
         exp_disp = {ph inside {M_IDLE, M_SHOW, M_ARMED, M_LOSE}, ph == M_SHOW, ph == M_ARMED,
                     ph == M_ARMED, ph == M_WIN, ph == M_LOSE};
         if (ph == M_SHOW)                     exp_sec = SHOW_S - t / TICK_DIV;
         else if (ph == M_ARMED)               exp_sec = TIME_S - t / TICK_DIV;
         else if (ph == M_WIN || ph == M_LOSE) exp_sec = fin;
         else                                  exp_sec = 0;
         chk("cyc_disp", {bomb_on, show_on, timer_on, input_on, success, fail}, exp_disp);
         chk("cyc_sec", sec_left, exp_sec);
         chk("cyc_code", code, m_code);
      end
   end

   function automatic logic [4:0] pred_code();
      logic [15:0] v;
      v = lfsr_step(lfsr_step(m_lfsr));
      return (v[4:0] == 5'd0) ? 5'd1 : v[4:0];
   endfunction

   task automatic press_start(input logic [4:0] avoid);
      int n;
      n = 0;
      while (pred_code() == avoid && n < 40) begin @(negedge clk); n++; end
      btn_start = 1'b1;
      n = 0;
      while (!show_on && n < 10) begin @(negedge clk); n++; end
      btn_start = 1'b0;
      chk("reach_show", show_on, 1);
   endtask

   task automatic wait_armed();
      int n;
      n = 0;
      while (!timer_on && n < 20) begin @(negedge clk); n++; end
      chk("reach_armed", timer_on, 1);
   endtask

   task automatic pulse_done(input logic ok);
      input_done = 1'b1;
      input_ok   = ok;
      @(negedge clk);
      input_done = 1'b0;
      input_ok   = 1'b0;
   endtask

   logic [4:0] code1;
   logic [4:0] code_hold;
   int n;

   initial begin
      rst_n = 1'b0; sw_en = 1'b0; btn_start = 1'b0; input_done = 1'b0; input_ok = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_outputs", {bomb_on, show_on, timer_on, input_on, success, fail}, 0);
      chk("rst_code", code, 0);
      chk("rst_sec", sec_left, 0);

      // power-up
      sw_en = 1'b1;
      rst_n = 1'b1;
      chk_on = 1'b1;
      n = 0;
      while (!bomb_on && n < 4) begin @(negedge clk); n++; end
      chk("pwr_idle_bomb", bomb_on, 1);
      chk("pwr_idle_others", {show_on, timer_on, input_on, success, fail}, 0);
      chk("pwr_code", code, 0);
      repeat (5) @(negedge clk);

      // win
      press_start(5'd0);
      n = 0;
      while (show_on && n < 20) begin n++; @(negedge clk); end
      chk("show_len", n, 8);
      chk("armed_timer", {timer_on, input_on, bomb_on}, 3'b111);
      chk("armed_sec", sec_left, 3);
      repeat (2) @(negedge clk);
      pulse_done(1'b1);
      chk("win_success", success, 1);
      chk("win_bomb", bomb_on, 0);
      chk("win_sec", sec_left, 3);
      code1 = code;
      chk("code1_nonzero", code1 != 5'd0, 1);
      pulse_done(1'b0);
      chk("win_ignores_done", success, 1);

      // timeout, also a second game with a fresh code
      press_start(code1);
      chk("code2_nonzero", code != 5'd0, 1);
      chk("codes_differ", code != code1, 1);
      wait_armed();
      n = 0;
      while (!fail && n < 20) begin @(negedge clk); n++; end
      chk("timeout_cycles", n, 12);
      chk("timeout_sec", sec_left, 0);
      chk("timeout_bomb", bomb_on, 1);

      // input_done on the same cycle as the expiring tick
      press_start(5'd0);
      wait_armed();
      repeat (11) @(negedge clk);
      pulse_done(1'b1);
      chk("simul_success", success, 1);
      chk("simul_fail", fail, 0);
      chk("simul_sec", sec_left, 1);

      // switch off mid-game
      press_start(5'd0);
      wait_armed();
      code_hold = code;
      repeat (2) @(negedge clk);
      sw_en = 1'b0;
      n = 0;
      while ((bomb_on | show_on | timer_on | input_on) && n < 6) begin @(negedge clk); n++; end
      chk("off_cycles", n, 3);
      chk("off_all_zero", {bomb_on, show_on, timer_on, input_on, success, fail, sec_left}, 0);
      chk("off_code_hold", code, code_hold);
      repeat (3) @(negedge clk);
      sw_en = 1'b1;
      n = 0;
      while (!bomb_on && n < 6) begin @(negedge clk); n++; end
      chk("on_idle", {bomb_on, show_on, timer_on}, 3'b100);
      repeat (4) @(negedge clk);

      // result hold
      press_start(5'd0);
      wait_armed();
      repeat (1) @(negedge clk);
      pulse_done(1'b0);
      chk("lose_fail", fail, 1);
      n = 0;
`ifdef BOMB_AUTO_RESTART_EN
      while (fail && n < 20) begin @(negedge clk); n++; end
      chk("lose_auto_cycles", n, 8);
      chk("lose_auto_idle", {bomb_on, fail, success}, 3'b100);
`else
      while (fail && n < 100) begin @(negedge clk); n++; end
      chk("lose_hold_cycles", n, 100);
      chk("lose_hold_bomb", bomb_on, 1);
`endif

      // reset mid-game returns through OFF
      press_start(5'd0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_outputs", {bomb_on, show_on, code}, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("midrst_idle", {bomb_on, show_on}, 2'b10);

      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
